hdbn_encoder: RTL and testbench

Parametrised HDBn line-code encoder that turns a NRZ bit stream into a fully substituted, polarity-assigned ternary symbol stream. It replaces the stand-alone V-marking stage: it detects runs of ZERO_RUN zeros, emits V, retroactively inserts B by the HDB3 parity rule, and applies alternate-mark inversion. It sits between the NRZ source and the dual-rail line driver, with `code_out` kept for downstream monitors.

---
 rtl/hdbn_encoder.sv | 107 ++++++++++
 tb/tb_hdbn_encoder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdbn_encoder.sv
// HDBn line-code encoder: zero-run substitution (B/V), HDB3 parity B insertion
// and alternate-mark inversion onto a dual-rail output, one symbol per strobe.
module hdbn_encoder #(
  parameter int unsigned ZERO_RUN = 4,
  parameter logic        INIT_POL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       data_in,
  output logic [1:0] code_out,
  output logic       pos_out,
  output logic       neg_out,
  output logic       valid_out
);

  localparam int unsigned CNT_W = $clog2(ZERO_RUN + 1);

  localparam logic [1:0] C_ZERO = 2'b00;
  localparam logic [1:0] C_MARK = 2'b01;
  localparam logic [1:0] C_V    = 2'b11;
  localparam logic [1:0] C_B    = 2'b10;

  logic [CNT_W-1:0] r_zc;
  logic [CNT_W-1:0] r_fill;
  logic             r_par;
  logic             r_last_pol;
  logic [1:0]       r_sr [ZERO_RUN];
  logic [1:0]       r_code;
  logic             r_pos;
  logic             r_neg;
  logic             r_valid;

  logic             w_run_done;
  logic             w_b_ins;
  logic [1:0]       w_new_code;
  logic [1:0]       w_leave;
  logic             w_pulse;
  logic             w_pol_upd;
  logic             w_pol;

  // Input stage: classify the incoming bit and decide on B insertion.
  always_comb begin
    w_run_done = 1'b0;
    w_new_code = C_ZERO;
    if (data_in) begin
      w_new_code = C_MARK;
    end else if (r_zc == CNT_W'(ZERO_RUN - 1)) begin
      w_run_done = 1'b1;
      w_new_code = C_V;
    end
    w_b_ins = w_run_done && !r_par;
  end

  // Output stage: polarity of the symbol leaving the delay line.
  always_comb begin
    w_leave   = r_sr[ZERO_RUN-1];
    w_pulse   = (w_leave != C_ZERO);
    w_pol_upd = (w_leave == C_MARK) || (w_leave == C_B);
    w_pol     = w_pol_upd ? ~r_last_pol : r_last_pol;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_zc       <= '0;
      r_par      <= 1'b0;
      r_last_pol <= INIT_POL;
      r_fill     <= '0;
      r_code     <= C_ZERO;
      r_pos      <= 1'b0;
      r_neg      <= 1'b0;
      r_valid    <= 1'b0;
      for (int i = 0; i < ZERO_RUN; i++) r_sr[i] <= C_ZERO;
    end else if (en) begin
      if (data_in) begin
        r_zc  <= '0;
        r_par <= ~r_par;
      end else if (w_run_done) begin
        r_zc  <= '0;
        r_par <= 1'b0;
      end else begin
        r_zc <= r_zc + 1'b1;
      end

      r_sr[0] <= w_new_code;
      for (int i = 1; i < ZERO_RUN; i++) r_sr[i] <= r_sr[i-1];
      // The run's first zero is one step from the end; rewrite it as B in flight.
      if (w_b_ins) r_sr[ZERO_RUN-1] <= C_B;

      r_code <= w_leave;
      r_pos  <= w_pulse && !w_pol;
      r_neg  <= w_pulse && w_pol;
      if (w_pol_upd) r_last_pol <= w_pol;

      if (r_fill != CNT_W'(ZERO_RUN)) r_fill <= r_fill + 1'b1;
      r_valid <= (r_fill == CNT_W'(ZERO_RUN));
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign code_out  = r_code;
  assign pos_out   = r_pos;
  assign neg_out   = r_neg;
  assign valid_out = r_valid;

endmodule

// File: tb/tb_hdbn_encoder.sv
// Scoreboard bench for hdbn_encoder: an HDB3 instance (4,1) and a ZERO_RUN=3,
// INIT_POL=0 instance share stimulus; each has its own reference model queue.
module tb_hdbn_encoder;

  localparam int unsigned ZR_A = 4;
  localparam int unsigned ZR_B = 3;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       data_in;
  logic [1:0] code_a, code_b;
  logic       pos_a, neg_a, valid_a;
  logic       pos_b, neg_b, valid_b;

  int n_tests;
  int n_fail;

  // Reference model state, index 0 = instance A, 1 = instance B.
  int         m_zc  [2];
  bit         m_par [2];
  bit         m_lp  [2];
  logic [1:0] q_a [$];
  logic [1:0] q_b [$];

  // Captured output symbols (valid only), cleared at every reset.
  logic [1:0] cap_code [2][$];
  bit         cap_pos  [2][$];
  bit         cap_neg  [2][$];

  hdbn_encoder #(.ZERO_RUN(ZR_A), .INIT_POL(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .data_in(data_in),
    .code_out(code_a), .pos_out(pos_a), .neg_out(neg_a), .valid_out(valid_a)
  );

  hdbn_encoder #(.ZERO_RUN(ZR_B), .INIT_POL(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .data_in(data_in),
    .code_out(code_b), .pos_out(pos_b), .neg_out(neg_b), .valid_out(valid_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_zc[0] = 0; m_par[0] = 1'b0; m_lp[0] = 1'b1;
    m_zc[1] = 0; m_par[1] = 1'b0; m_lp[1] = 1'b0;
    q_a.delete(); q_b.delete();
    for (int k = 0; k < 2; k++) begin
      cap_code[k].delete(); cap_pos[k].delete(); cap_neg[k].delete();
    end
  endtask

  // Push the expected symbol for one accepted bit; a B rewrites an already-queued zero.
  task automatic model_push(input int id, input bit d);
    int zr;
    logic [1:0] c;
    bit b_ins;
    zr = (id == 0) ? ZR_A : ZR_B;
    b_ins = 1'b0;
    if (d) begin
      c = 2'b01; m_zc[id] = 0; m_par[id] = ~m_par[id];
    end else if (m_zc[id] < zr - 1) begin
      c = 2'b00; m_zc[id]++;
    end else begin
      c = 2'b11; m_zc[id] = 0; b_ins = !m_par[id]; m_par[id] = 1'b0;
    end
    if (id == 0) begin
      q_a.push_back(c);
      if (b_ins) q_a[q_a.size() - zr] = 2'b10;
    end else begin
      q_b.push_back(c);
      if (b_ins) q_b[q_b.size() - zr] = 2'b10;
    end
  endtask

  task automatic score(input int id);
    bit v, p, n, exp_v, ep, en_, pulse, pol;
    logic [1:0] c, ec;
    int sz, zr;
    if (id == 0) begin
      v = valid_a; c = code_a; p = pos_a; n = neg_a; sz = q_a.size(); zr = ZR_A;
    end else begin
      v = valid_b; c = code_b; p = pos_b; n = neg_b; sz = q_b.size(); zr = ZR_B;
    end
    exp_v = (sz > zr);
    n_tests++;
    if (v !== exp_v) begin
      n_fail++;
      $display("FAIL valid[%0d] got=%0b exp=%0b", id, v, exp_v);
    end
    if (exp_v) begin
      ec = (id == 0) ? q_a.pop_front() : q_b.pop_front();
      pulse = (ec != 2'b00);
      if (ec == 2'b11) pol = m_lp[id];
      else begin
        pol = ~m_lp[id];
        if (pulse) m_lp[id] = pol;
      end
      ep  = pulse && !pol;
      en_ = pulse && pol;
      n_tests++;
      if (c !== ec || p !== ep || n !== en_) begin
        n_fail++;
        $display("FAIL symbol[%0d] got code=%b pos=%0b neg=%0b exp code=%b pos=%0b neg=%0b",
                 id, c, p, n, ec, ep, en_);
      end
      cap_code[id].push_back(c); cap_pos[id].push_back(p); cap_neg[id].push_back(n);
    end
  endtask

  task automatic strobe(input bit d);
    en = 1'b1; data_in = d;
    model_push(0, d);
    model_push(1, d);
    @(posedge clk); #1;
    en = 1'b0;
    score(0);
    score(1);
  endtask

  // en low: outputs must hold and valid_out must stay low.
  task automatic idle(input int cycles);
    logic [1:0] ca, cb;
    bit pa, na, pb, nb;
    ca = code_a; pa = pos_a; na = neg_a; cb = code_b; pb = pos_b; nb = neg_b;
    en = 1'b0;
    repeat (cycles) begin
      @(posedge clk); #1;
      n_tests++;
      if (valid_a !== 1'b0 || valid_b !== 1'b0 || code_a !== ca || pos_a !== pa ||
          neg_a !== na || code_b !== cb || pos_b !== pb || neg_b !== nb) begin
        n_fail++;
        $display("FAIL hold got a=%b/%0b/%0b/%0b b=%b/%0b/%0b/%0b exp a=%b/%0b/%0b/0 b=%b/%0b/%0b/0",
                 code_a, pos_a, neg_a, valid_a, code_b, pos_b, neg_b, valid_b,
                 ca, pa, na, cb, pb, nb);
      end
    end
  endtask

  task automatic test_reset(input int cycles);
    rst_n = 1'b0; en = 1'b1; data_in = 1'b1;
    repeat (cycles) begin
      @(posedge clk); #1;
      n_tests++;
      if ({code_a, pos_a, neg_a, valid_a, code_b, pos_b, neg_b, valid_b} !== 10'b0) begin
        n_fail++;
        $display("FAIL reset got a=%b/%0b/%0b/%0b b=%b/%0b/%0b/%0b exp all 0",
                 code_a, pos_a, neg_a, valid_a, code_b, pos_b, neg_b, valid_b);
      end
    end
    rst_n = 1'b1; en = 1'b0; data_in = 1'b0;
    model_reset();
  endtask

  task automatic flush();
    repeat (ZR_A) strobe(1'b1);
  endtask

  task automatic check_seq(input string name, input int id, input int len,
                           input logic [1:0] ec [12], input bit ep [12], input bit en_ [12]);
    n_tests++;
    if (cap_code[id].size() < len) begin
      n_fail++;
      $display("FAIL %s length got=%0d exp>=%0d", name, cap_code[id].size(), len);
    end else begin
      for (int i = 0; i < len; i++) begin
        n_tests++;
        if (cap_code[id][i] !== ec[i] || cap_pos[id][i] !== ep[i] || cap_neg[id][i] !== en_[i]) begin
          n_fail++;
          $display("FAIL %s[%0d] got code=%b pos=%0b neg=%0b exp code=%b pos=%0b neg=%0b",
                   name, i, cap_code[id][i], cap_pos[id][i], cap_neg[id][i], ec[i], ep[i], en_[i]);
        end
      end
    end
  endtask

  task automatic test_all_ones();
    logic [1:0] ec [12];
    bit ep [12], en_ [12];
    test_reset(1);
    repeat (12) strobe(1'b1);
    for (int i = 0; i < 12; i++) begin
      ec[i] = 2'b01; ep[i] = (i % 2 == 0); en_[i] = (i % 2 == 1);
    end
    check_seq("all_ones", 0, 8, ec, ep, en_);
  endtask

  task automatic test_b00v();
    logic [1:0] ec [12] = '{2'b10, 2'b00, 2'b00, 2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 0, 0, 0, 0};
    bit ep [12]  = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    bit en_ [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    test_reset(1);
    repeat (4) strobe(1'b0);
    flush();
    check_seq("b00v", 0, 4, ec, ep, en_);
  endtask

  task automatic test_long_run(input int gap);
    logic [1:0] ec [12] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b11, 2'b10, 2'b00, 2'b00, 2'b11, 0, 0, 0};
    bit ep [12]  = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    bit en_ [12] = '{0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0};
    bit bits [9] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    test_reset(1);
    for (int i = 0; i < 9; i++) begin
      strobe(bits[i]);
      if (gap > 0) idle(gap);
    end
    flush();
    check_seq(gap > 0 ? "long_run_gaps" : "long_run", 0, 9, ec, ep, en_);
  endtask

  task automatic test_reset_mid_run();
    logic [1:0] ec [12] = '{2'b10, 2'b00, 2'b00, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0};
    bit ep [12]  = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    bit en_ [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    test_reset(1);
    repeat (2) strobe(1'b0);
    test_reset(1);
    repeat (4) strobe(1'b0);
    flush();
    check_seq("reset_mid_run", 0, 4, ec, ep, en_);
  endtask

  task automatic test_zr3();
    logic [1:0] ec [12] = '{2'b01, 2'b00, 2'b00, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0};
    bit ep [12]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    bit en_ [12] = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    test_reset(1);
    strobe(1'b1);
    repeat (3) strobe(1'b0);
    flush();
    check_seq("zr3", 1, 4, ec, ep, en_);
  endtask

  task automatic test_random();
    test_reset(2);
    for (int i = 0; i < 300; i++) begin
      strobe($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
    end
    flush();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    en      = 1'b0;
    data_in = 1'b0;
    model_reset();
    test_reset(3);
    test_all_ones();
    test_b00v();
    test_long_run(0);
    test_long_run(2);
    test_reset_mid_run();
    test_zr3();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
